// File: rtl/uart8_rx_controller.sv
// uart8_rx_controller: sequences an 8-bit UART receiver and buffers its bytes in a valid/ready FIFO.
// Optional idle timeout is built only when UART8_RX_CTRL_TIMEOUT_EN is defined.
module uart8_rx_controller #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ERR_LIMIT  = 3,
  parameter int unsigned ERR_CNT_W  = 8,
  parameter int unsigned IDLE_TICKS = 160
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          ctrl_en_i,
  input  logic                          clear_i,
  input  logic                          rx_busy_i,
  input  logic                          rx_done_i,
  input  logic                          rx_err_i,
  input  logic [7:0]                    rx_data_i,
  output logic                          rx_en_o,
  output logic [7:0]                    m_data_o,
  output logic                          m_valid_o,
  input  logic                          m_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
  output logic                          overrun_o,
  output logic [ERR_CNT_W-1:0]          err_count_o,
  output logic                          rx_idle_o
);

  localparam int unsigned PtrW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW    = PtrW + 1;
  localparam int unsigned ConsecW = $clog2(ERR_LIMIT + 1);

  localparam logic [CntW-1:0]    FullCnt  = CntW'(FIFO_DEPTH);
  localparam logic [ConsecW-1:0] LimitCnt = ConsecW'(ERR_LIMIT);

  typedef enum logic [1:0] {StOff, StWarm, StRun, StRecover} state_e;

  state_e               state_q, state_d;
  logic                 phase_q, phase_d;
  logic                 done_q, err_q;
  logic [ConsecW-1:0]   consec_q, consec_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [7:0]           mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]      count_q, count_d;
  logic                 overrun_q, overrun_d;

  logic run, done_rise, err_rise, push_req, push_ok, pop, full, recover_req;

  assign run       = (state_q == StRun);
  assign done_rise = rx_done_i & ~done_q;
  assign err_rise  = rx_err_i & ~err_q;
  assign push_req  = run & done_rise;
  assign full      = (count_q == FullCnt);
  assign pop       = m_valid_o & m_ready_i;
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign push_ok   = push_req & (~full | pop);

  assign m_valid_o    = (count_q != '0);
  assign m_data_o     = mem_q[rd_ptr_q];
  assign fifo_count_o = count_q;
  assign overrun_o    = overrun_q;
  assign err_count_o  = err_cnt_q;

  // Consecutive error tracking; a byte landing with an error edge restarts the run at one.
  always_comb begin
    consec_d    = consec_q;
    recover_req = 1'b0;
    if (clear_i) begin
      consec_d = '0;
    end else if (run) begin
      if (err_rise) begin
        consec_d = push_ok ? ConsecW'(1) : consec_q + 1'b1;
      end else if (push_ok) begin
        consec_d = '0;
      end
      if (consec_d == LimitCnt) begin
        recover_req = 1'b1;
        consec_d    = '0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    rx_en_o = 1'b0;
    case (state_q)
      StOff: begin
        if (ctrl_en_i) begin
          state_d = StWarm;
          phase_d = 1'b0;
        end
      end
      StWarm: begin
        rx_en_o = 1'b1;
        if (phase_q) begin
          state_d = StRun;
          phase_d = 1'b0;
        end else begin
          phase_d = 1'b1;
        end
      end
      StRun: begin
        rx_en_o = 1'b1;
        if (recover_req) begin
          state_d = StRecover;
          phase_d = 1'b0;
        end
      end
      StRecover: begin
        if (phase_q) begin
          state_d = StWarm;
          phase_d = 1'b0;
        end else begin
          phase_d = 1'b1;
        end
      end
      default: begin
        state_d = StOff;
        phase_d = 1'b0;
      end
    endcase
    if (!ctrl_en_i) begin
      state_d = StOff;
      phase_d = 1'b0;
    end
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    err_cnt_d = err_cnt_q;
    if (clear_i) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      overrun_d = 1'b0;
      err_cnt_d = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
      if (push_ok && !pop) begin
        count_d = count_q + 1'b1;
      end else if (pop && !push_ok) begin
        count_d = count_q - 1'b1;
      end
      if (push_req && full && !pop) overrun_d = 1'b1;
      if (run && err_rise && !(&err_cnt_q)) err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StOff;
      phase_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      consec_q  <= '0;
      err_cnt_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      done_q    <= rx_done_i;
      err_q     <= rx_err_i;
      consec_q  <= consec_d;
      err_cnt_q <= err_cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  // Storage needs no reset; occupancy alone defines which entries are meaningful.
  always_ff @(posedge clk_i) begin
    if (push_ok && !clear_i) mem_q[wr_ptr_q] <= rx_data_i;
  end

`ifdef UART8_RX_CTRL_TIMEOUT_EN
  localparam int unsigned IdleW = $clog2(IDLE_TICKS + 1);
  localparam logic [IdleW-1:0] IdleLast = IdleW'(IDLE_TICKS - 1);

  logic [IdleW-1:0] idle_cnt_q, idle_cnt_d;
  logic             idle_q, idle_d;
  logic             armed_q, armed_d;

  // Armed by a push so that a long silence is reported once, not repeatedly.
  always_comb begin
    idle_cnt_d = idle_cnt_q;
    idle_d     = idle_q;
    armed_d    = armed_q;
    if (clear_i) begin
      idle_cnt_d = '0;
      idle_d     = 1'b0;
      armed_d    = 1'b0;
    end else if (push_ok) begin
      idle_cnt_d = '0;
      idle_d     = 1'b0;
      armed_d    = 1'b1;
    end else if (rx_busy_i) begin
      idle_cnt_d = '0;
    end else if (run && armed_q) begin
      if (idle_cnt_q == IdleLast) begin
        idle_cnt_d = '0;
        idle_d     = 1'b1;
        armed_d    = 1'b0;
      end else begin
        idle_cnt_d = idle_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idle_cnt_q <= '0;
      idle_q     <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
      idle_q     <= idle_d;
      armed_q    <= armed_d;
    end
  end

  assign rx_idle_o = idle_q;
`else
  logic unused_busy;
  assign unused_busy = rx_busy_i;
  assign rx_idle_o   = 1'b0;
`endif

endmodule

// File: tb/tb_uart8_rx_controller.sv
// Directed bench for uart8_rx_controller; a byte scoreboard checks every FIFO pop in order.
module tb_uart8_rx_controller;

  logic       clk = 1'b0;
  logic       rst, ctrl_en, clear, rx_busy, rx_done, rx_err, m_ready;
  logic [7:0] rx_data;
  logic       rx_en, m_valid, overrun, rx_idle;
  logic [7:0] m_data;
  logic [2:0] fifo_count;
  logic [7:0] err_count;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [7:0]  exp_q[$];

  always #5 clk = ~clk;

  uart8_rx_controller dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .ctrl_en_i   (ctrl_en),
    .clear_i     (clear),
    .rx_busy_i   (rx_busy),
    .rx_done_i   (rx_done),
    .rx_err_i    (rx_err),
    .rx_data_i   (rx_data),
    .rx_en_o     (rx_en),
    .m_data_o    (m_data),
    .m_valid_o   (m_valid),
    .m_ready_i   (m_ready),
    .fifo_count_o(fifo_count),
    .overrun_o   (overrun),
    .err_count_o (err_count),
    .rx_idle_o   (rx_idle)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_rx_en"}, 32'(rx_en), 32'd0);
    check({tag, "_m_valid"}, 32'(m_valid), 32'd0);
    check({tag, "_count"}, 32'(fifo_count), 32'd0);
    check({tag, "_overrun"}, 32'(overrun), 32'd0);
    check({tag, "_err_count"}, 32'(err_count), 32'd0);
    check({tag, "_rx_idle"}, 32'(rx_idle), 32'd0);
  endtask

  // 16-tick done hold, optionally with an error edge on the first tick.
  task automatic send_byte(input logic [7:0] b, input logic with_err, input logic expect_push);
    rx_data = b;
    rx_done = 1'b1;
    rx_err  = with_err;
    if (expect_push) exp_q.push_back(b);
    tick(1);
    rx_err = 1'b0;
    tick(15);
    rx_done = 1'b0;
    tick(1);
  endtask

  task automatic err_pulse();
    rx_err = 1'b1;
    tick(1);
    rx_err = 1'b0;
    tick(1);
  endtask

  // Scoreboard: each accepted pop must deliver the oldest expected byte.
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        check("pop_unexpected", 32'(m_valid), 32'd0);
      end else begin
        check("pop_data", 32'(m_data), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    rst = 1'b1; ctrl_en = 1'b0; clear = 1'b0; rx_busy = 1'b0;
    rx_done = 1'b0; rx_err = 1'b0; rx_data = 8'h00; m_ready = 1'b0;
    tick(2);
    check_reset("reset");
    rst = 1'b0;
    tick(1);
    check("off_rx_en", 32'(rx_en), 32'd0);

    // Enable sequence; a done edge during warm-up must be ignored.
    ctrl_en = 1'b1;
    tick(1);
    check("warm_rx_en", 32'(rx_en), 32'd1);
    rx_data = 8'h5A; rx_done = 1'b1;
    tick(1);
    rx_done = 1'b0;
    tick(1);
    check("warm_no_capture", 32'(fifo_count), 32'd0);
    send_byte(8'hA5, 1'b0, 1'b1);
    check("single_push_count", 32'(fifo_count), 32'd1);
    check("single_push_valid", 32'(m_valid), 32'd1);
    check("single_push_data", 32'(m_data), 32'(exp_q[0]));

    // Overflow with the host stalled, then clear.
    m_ready = 1'b1;
    tick(1);
    m_ready = 1'b0;
    check("drain1_count", 32'(fifo_count), 32'd0);
    for (int b = 1; b <= 5; b++) send_byte(8'(b), 1'b0, b <= 4);
    check("full_count", 32'(fifo_count), 32'd4);
    check("full_overrun", 32'(overrun), 32'd1);
    check("full_head", 32'(m_data), 32'(exp_q[0]));
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    exp_q.delete();
    check("clear_count", 32'(fifo_count), 32'd0);
    check("clear_overrun", 32'(overrun), 32'd0);
    check("clear_valid", 32'(m_valid), 32'd0);

    // Push into a full FIFO while the head is popped.
    for (int b = 8'h11; b <= 8'h14; b++) send_byte(8'(b), 1'b0, 1'b1);
    check("refill_overrun", 32'(overrun), 32'd0);
    rx_data = 8'h77; rx_done = 1'b1; m_ready = 1'b1;
    exp_q.push_back(8'h77);
    tick(1);
    m_ready = 1'b0;
    tick(15);
    rx_done = 1'b0;
    tick(1);
    check("push_pop_count", 32'(fifo_count), 32'd4);
    check("push_pop_overrun", 32'(overrun), 32'd0);
    m_ready = 1'b1;
    tick(4);
    m_ready = 1'b0;
    check("drain2_count", 32'(fifo_count), 32'd0);

    // Three consecutive errors force a recovery.
    err_pulse();
    err_pulse();
    check("err2_count", 32'(err_count), 32'd2);
    check("err2_rx_en", 32'(rx_en), 32'd1);
    rx_err = 1'b1;
    tick(1);
    check("recover_rx_en_a", 32'(rx_en), 32'd0);
    check("err3_count", 32'(err_count), 32'd3);
    rx_err = 1'b0;
    tick(1);
    check("recover_rx_en_b", 32'(rx_en), 32'd0);
    tick(1);
    check("rewarm_rx_en", 32'(rx_en), 32'd1);
    tick(2);
    err_pulse();
    send_byte(8'h31, 1'b0, 1'b1);
    err_pulse();
    err_pulse();
    check("no_recover_rx_en", 32'(rx_en), 32'd1);
    check("err6_count", 32'(err_count), 32'd6);
    send_byte(8'h32, 1'b1, 1'b1);
    check("simul_rx_en", 32'(rx_en), 32'd1);
    check("err7_count", 32'(err_count), 32'd7);
    err_pulse();
    check("simul_plus1_rx_en", 32'(rx_en), 32'd1);
    err_pulse();
    check("simul_plus2_rx_en", 32'(rx_en), 32'd0);
    check("err9_count", 32'(err_count), 32'd9);
    tick(3);
    m_ready = 1'b1;
    tick(2);
    m_ready = 1'b0;
    check("drain3_count", 32'(fifo_count), 32'd0);

    // Idle timeout.
    send_byte(8'h41, 1'b0, 1'b1);
`ifdef UART8_RX_CTRL_TIMEOUT_EN
    tick(143);
    check("idle_tick159", 32'(rx_idle), 32'd0);
    tick(1);
    check("idle_tick160", 32'(rx_idle), 32'd1);
    rx_data = 8'h42; rx_done = 1'b1;
    exp_q.push_back(8'h42);
    tick(1);
    check("idle_cleared", 32'(rx_idle), 32'd0);
    tick(15);
    rx_done = 1'b0;
    tick(1);
`else
    tick(170);
    check("idle_disabled", 32'(rx_idle), 32'd0);
`endif

    // Reset in the middle of a done pulse, then no capture before RUN.
    rx_data = 8'h55; rx_done = 1'b1;
    exp_q.push_back(8'h55);
    tick(3);
    check("pre_rst_valid", 32'(m_valid), 32'd1);
    rst = 1'b1;
    #1;
    check_reset("rst_done");
    exp_q.delete();
    tick(1);
    rst = 1'b0;
    tick(1);
    rx_done = 1'b0;
    tick(1);
    rx_done = 1'b1;
    tick(4);
    check("rst_no_capture", 32'(fifo_count), 32'd0);
    rx_done = 1'b0;
    tick(1);

    // Reset while recovering.
    send_byte(8'h66, 1'b0, 1'b1);
    err_pulse();
    err_pulse();
    rx_err = 1'b1;
    tick(1);
    rx_err = 1'b0;
    check("pre_rst_recover_rx_en", 32'(rx_en), 32'd0);
    rst = 1'b1;
    #1;
    check_reset("rst_recover");
    exp_q.delete();
    tick(1);
    rst = 1'b0;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
